uart_param_core: RTL

Parametrised full-duplex UART core, the next generation of the team's fixed 8N1 transceiver.
- Adds configurable data width and a runtime baud divisor.
- Adds runtime parity (none/even/odd) and 1 or 2 stop bits.
- Receiver uses 16x oversampling with 3-sample majority voting, and reports parity and framing errors.
- Sits between the system bus register block and the board-level TX/RX pins.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_param_core.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the parametrised UART core.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Mode 2'b11 is treated as no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator shared by the TX and RX state machines.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DIV_WIDTH-1:0] BaudDiv,
  output logic                 Tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;

  // The divisor is captured at each wrap so a mid-period change cannot strand the counter.
  assign Tick = (cnt == div_q);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (Tick) begin
      cnt   <= '0;
      div_q <= BaudDiv;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART with runtime divisor, parity and stop-bit count; 3-sample majority RX.
//   state     | meaning
//   ST_IDLE   | line idle; TX waits for a load, RX waits for a low level
//   ST_START  | start bit (TX first waits for a tick to align the falling edge)
//   ST_DATA   | payload bits, LSB first
//   ST_PARITY | optional parity bit
//   ST_STOP   | stop bit(s); RX finishes at the first stop-bit decision
module uart_param_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DIV_WIDTH-1:0] BaudDiv,
  input  logic [1:0]           ParityMode,
  input  logic                 TwoStop,
  input  logic                 TxDataLoad,
  input  logic [DATA_BITS-1:0] TxDataIn,
  output logic                 TxReady,
  output logic                 TxDataOut,
  output logic                 TxDone,
  input  logic                 RxDataIn,
  output logic [DATA_BITS-1:0] RxDataOut,
  output logic                 RxDone,
  output logic                 RxParityError,
  output logic                 RxFrameError
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] T_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] T_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] T_S2   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud_gen (
    .Clock  (Clock),
    .Reset  (Reset),
    .BaudDiv(BaudDiv),
    .Tick   (tick)
  );

  uart_state_t          tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par_bit;
  logic                 tx_par_en;
  logic                 tx_two;
  logic                 tx_stop2;
  logic                 tx_armed;
  logic                 tx_end;

  assign tx_end = tick && tx_armed && (tx_cnt == T_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tx_state   <= ST_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      tx_par_bit <= 1'b0;
      tx_par_en  <= 1'b0;
      tx_two     <= 1'b0;
      tx_stop2   <= 1'b0;
      tx_armed   <= 1'b0;
      TxDataOut  <= 1'b1;
      TxReady    <= 1'b1;
      TxDone     <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      if (tick && tx_armed)
        tx_cnt <= (tx_cnt == T_LAST) ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        ST_IDLE: begin
          if (TxDataLoad && TxReady) begin
            tx_sh      <= TxDataIn;
            tx_par_bit <= (^TxDataIn) ^ (ParityMode == PAR_ODD);
            tx_par_en  <= parity_on(ParityMode);
            tx_two     <= TwoStop;
            tx_cnt     <= '0;
            TxReady    <= 1'b0;
            tx_state   <= ST_START;
          end
        end
        ST_START: begin
          // The start edge waits for the next tick so every bit is a whole number of ticks.
          if (tick && !tx_armed) begin
            TxDataOut <= 1'b0;
            tx_armed  <= 1'b1;
          end else if (tx_end) begin
            tx_bit    <= '0;
            TxDataOut <= tx_sh[0];
            tx_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_end) begin
            if (tx_bit == BIT_LAST) begin
              tx_stop2 <= 1'b0;
              if (tx_par_en) begin
                TxDataOut <= tx_par_bit;
                tx_state  <= ST_PARITY;
              end else begin
                TxDataOut <= 1'b1;
                tx_state  <= ST_STOP;
              end
            end else begin
              tx_bit    <= tx_bit + 1'b1;
              tx_sh     <= tx_sh >> 1;
              TxDataOut <= tx_sh[1];
            end
          end
        end
        ST_PARITY: begin
          if (tx_end) begin
            TxDataOut <= 1'b1;
            tx_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tx_end) begin
            if (tx_two && !tx_stop2) begin
              tx_stop2 <= 1'b1;
            end else begin
              tx_armed <= 1'b0;
              TxDone   <= 1'b1;
              TxReady  <= 1'b1;
              tx_state <= ST_IDLE;
            end
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  logic                 rx_meta;
  logic                 rx_s;
  uart_state_t          rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_s0;
  logic                 rx_s1;
  logic                 rx_par_en;
  logic                 rx_par_odd;
  logic                 rx_perr;
  logic                 rx_active;
  logic                 rx_mid;
  logic                 rx_end;
  logic                 rx_bit_v;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RxDataIn;
      rx_s    <= rx_meta;
    end
  end

  assign rx_active = (rx_state != ST_IDLE);
  assign rx_mid    = tick && rx_active && (rx_cnt == T_S2);
  assign rx_end    = tick && rx_active && (rx_cnt == T_LAST);
  assign rx_bit_v  = maj3(rx_s0, rx_s1, rx_s);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_state      <= ST_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_s0         <= 1'b1;
      rx_s1         <= 1'b1;
      rx_par_en     <= 1'b0;
      rx_par_odd    <= 1'b0;
      rx_perr       <= 1'b0;
      RxDataOut     <= '0;
      RxDone        <= 1'b0;
      RxParityError <= 1'b0;
      RxFrameError  <= 1'b0;
    end else begin
      RxDone <= 1'b0;
      if (tick && rx_active) begin
        rx_cnt <= (rx_cnt == T_LAST) ? '0 : rx_cnt + 1'b1;
        if (rx_cnt == T_S0) rx_s0 <= rx_s;
        if (rx_cnt == T_S1) rx_s1 <= rx_s;
      end
      case (rx_state)
        ST_IDLE: begin
          if (!rx_s) begin
            rx_cnt     <= '0;
            rx_perr    <= 1'b0;
            rx_par_en  <= parity_on(ParityMode);
            rx_par_odd <= (ParityMode == PAR_ODD);
            rx_state   <= ST_START;
          end
        end
        ST_START: begin
          if (rx_mid && rx_bit_v) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
          end else if (rx_end) begin
            rx_bit   <= '0;
            rx_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_mid)
            rx_sh <= {rx_bit_v, rx_sh[DATA_BITS-1:1]};
          if (rx_end) begin
            if (rx_bit == BIT_LAST)
              rx_state <= rx_par_en ? ST_PARITY : ST_STOP;
            else
              rx_bit <= rx_bit + 1'b1;
          end
        end
        ST_PARITY: begin
          if (rx_mid)
            rx_perr <= rx_bit_v ^ (^rx_sh) ^ rx_par_odd;
          if (rx_end)
            rx_state <= ST_STOP;
        end
        ST_STOP: begin
          // Finish mid-stop so a start edge half a bit later is still caught.
          if (rx_mid) begin
            RxDone        <= 1'b1;
            RxDataOut     <= rx_sh;
            RxParityError <= rx_perr;
            RxFrameError  <= ~rx_bit_v;
            rx_cnt        <= '0;
            rx_state      <= ST_IDLE;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
